// File: rtl/uart_axis_pkg.sv
// Shared types and defaults for the AXIS-UART receive and transmit paths.
package uart_axis_pkg;

  localparam int unsigned DEF_DATA_BITS    = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_IDLE_BITS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Width of the intra-bit cycle counter.
  function automatic int unsigned bit_cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture and re-time the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_axis_framer.sv
// UART receiver feeding an AXI-Stream master; tlast closes a packet after an
// idle line. Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_rx_axis_framer
  import uart_axis_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned CNT_W    = bit_cnt_width(CLKS_PER_BIT);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS + 1);
  localparam int unsigned IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W   = $clog2(IDLE_LIM + 1);

  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_M1  = IDLE_W'(IDLE_LIM - 1);

  logic                 rxs;
  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [DATA_BITS-1:0] pend_data;
  logic                 pend_valid;
  logic                 stop_smp_c;
  logic                 byte_ok_c;
  logic                 start_entry_c;
  logic                 idle_done_c;
  logic                 out_free_c;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rxs)
  );

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Frame sequencing: mid-bit sampling, LSB first.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CNT_W'(1);
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    stop_smp_c = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (!rxs) state_nxt = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt   = '0;
          state_nxt = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
          bit_nxt   = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt    = '0;
          stop_smp_c = 1'b1;
          state_nxt  = rxs ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_nxt = '0;
        if (rxs) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad_c;

  assign par_bad_c = ^{shreg, par_bit};
  assign byte_ok_c = stop_smp_c && rxs && !par_bad_c;

  // Capture the parity bit and flag a mismatch (framing error wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == ST_PARITY && cnt == FULL_M1) par_bit <= rxs;
      parity_err <= stop_smp_c && rxs && par_bad_c;
    end
  end
`else
  assign byte_ok_c  = stop_smp_c && rxs;
  assign parity_err = 1'b0;
`endif

  assign start_entry_c = (state == ST_IDLE) && !rxs;
  assign idle_done_c   = (state == ST_IDLE) && pend_valid && (idle_cnt == IDLE_M1);
  assign out_free_c    = !m_axis_tvalid || m_axis_tready;

  // Line-idle timer for packet closure; saturates while the output is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (start_entry_c || byte_ok_c) begin
      idle_cnt <= '0;
    end else if (state == ST_IDLE && pend_valid && idle_cnt != IDLE_M1) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Pending/output buffering, AXIS handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data     <= '0;
      pend_valid    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= stop_smp_c && !rxs;
      overrun   <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (byte_ok_c) begin
        if (!pend_valid) begin
          pend_data  <= shreg;
          pend_valid <= 1'b1;
        end else if (out_free_c) begin
          m_axis_tdata  <= pend_data;
          m_axis_tlast  <= 1'b0;
          m_axis_tvalid <= 1'b1;
          pend_data     <= shreg;
        end else begin
          overrun <= 1'b1;
        end
      end else if (idle_done_c && out_free_c) begin
        m_axis_tdata  <= pend_data;
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
        pend_valid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis_framer.sv
// Self-checking bench for uart_rx_axis_framer (parity cases when
// UART_RX_PARITY_EN is defined).
module tb_uart_rx_axis_framer;

  localparam int unsigned CPB = 16;
  localparam int unsigned DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  uart_rx_axis_framer #(
    .DATA_BITS    (DW),
    .CLKS_PER_BIT (CPB),
    .IDLE_BITS    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          idle;
    logic          push;
    logic          last;
  } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  time   got_t[$];

  int unsigned ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, stab_err = 0;
  int unsigned exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  int unsigned tests = 0, fails = 0;

  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  // Output monitor: collects accepted beats, error pulses and stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && (!m_axis_tvalid || m_axis_tdata != prev_data || m_axis_tlast != prev_last))
        stab_err++;
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(beat_t'{m_axis_tdata, m_axis_tlast});
        got_t.push_back($time);
      end
      ferr_cnt += 32'(frame_err);
      ovr_cnt  += 32'(overrun);
      perr_cnt += 32'(parity_err);
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            input int stop_cyc);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
    if (PAR_ON) drive_bit(par, CPB);
    drive_bit(stop, stop_cyc);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) tick(1);
    tick(20);
  endtask

  task automatic check_beats(input string name, output time t_first);
    beat_t e, g;
    time   t;
    bit    first = 1'b1;
    t_first = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (got_q.size() == 0) begin
        fails++;
        $display("FAIL %s: beat data=0x%02h last=%0b missing", name, e.data, e.last);
      end else begin
        g = got_q.pop_front();
        t = got_t.pop_front();
        if (first) t_first = t;
        first = 1'b0;
        if (g !== e)
          begin
            fails++;
            $display("FAIL %s: got data=0x%02h last=%0b expected data=0x%02h last=%0b",
                     name, g.data, g.last, e.data, e.last);
          end
      end
    end
    chk({name, " extra beats"}, got_q.size(), 0);
    got_q.delete();
    got_t.delete();
  endtask

  task automatic check_errs(input string name);
    chk({name, " frame_err count"}, ferr_cnt, exp_ferr);
    chk({name, " overrun count"}, ovr_cnt, exp_ovr);
    chk({name, " parity_err count"}, perr_cnt, exp_perr);
  endtask

  vec_t vecs[8];
  time  t0, tf;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h33, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    #22;
    chk("reset tvalid", 32'(m_axis_tvalid), 0);
    chk("reset tdata", 32'(m_axis_tdata), 0);
    chk("reset tlast", 32'(m_axis_tlast), 0);
    chk("reset errs", {29'd0, frame_err, overrun, parity_err}, 0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      if (i == 0) t0 = $time;
      send_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, CPB);
      if (vecs[i].push) exp_q.push_back(beat_t'{vecs[i].data, vecs[i].last});
      if (!vecs[i].stop) exp_ferr++;
      if (vecs[i].idle) begin
        drain(400);
        check_beats($sformatf("vec%0d", i), tf);
        check_errs($sformatf("vec%0d", i));
        if (i == 0) begin
          tests++;
          if (tf < t0 + 2150 + 160 * PAR_ON || tf > t0 + 2240 + 160 * PAR_ON) begin
            fails++;
            $display("FAIL single-byte latency: beat at %0t ns after start bit", tf - t0);
          end
        end
      end
    end

    // Stop bit low with the line held low, then a clean byte
    send_frame(8'h5A, ^8'h5A, 1'b0, 40);
    exp_ferr++;
    tick(5);
    send_frame(8'h3C, ^8'h3C, 1'b1, CPB);
    exp_q.push_back(beat_t'{8'h3C, 1'b1});
    drain(400);
    check_beats("break recovery", tf);
    check_errs("break recovery");

    // Stalled sink: third byte overruns
    m_axis_tready = 1'b0;
    send_frame(8'h01, ^8'h01, 1'b1, CPB);
    send_frame(8'h02, ^8'h02, 1'b1, CPB);
    send_frame(8'h03, ^8'h03, 1'b1, CPB);
    exp_ovr++;
    tick(120);
    chk("stall tvalid", 32'(m_axis_tvalid), 1);
    chk("stall tdata", 32'(m_axis_tdata), 32'h01);
    chk("stall tlast", 32'(m_axis_tlast), 0);
    chk("stall no beats", got_q.size(), 0);
    check_errs("overrun");
    exp_q.push_back(beat_t'{8'h01, 1'b0});
    exp_q.push_back(beat_t'{8'h02, 1'b1});
    m_axis_tready = 1'b1;
    drain(400);
    check_beats("overrun drain", tf);
    check_errs("overrun drain");

    // Short glitch on an idle line
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 80);
    chk("glitch no beat", got_q.size(), 0);
    check_errs("glitch");

    // Reset in the middle of a frame with a beat parked at the output
    m_axis_tready = 1'b0;
    send_frame(8'h77, ^8'h77, 1'b1, CPB);
    tick(100);
    chk("parked tvalid", 32'(m_axis_tvalid), 1);
    chk("parked tdata", 32'(m_axis_tdata), 32'h77);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, 40);
    rst_n = 1'b0;
    #1;
    chk("midreset tvalid", 32'(m_axis_tvalid), 0);
    chk("midreset tdata", 32'(m_axis_tdata), 0);
    chk("midreset tlast", 32'(m_axis_tlast), 0);
    tick(3);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    tick(250);
    chk("post-reset no beat", got_q.size(), 0);
    check_errs("post-reset");

`ifdef UART_RX_PARITY_EN
    // Even parity accepted, then rejected
    send_frame(8'h07, 1'b1, 1'b1, CPB);
    exp_q.push_back(beat_t'{8'h07, 1'b1});
    drain(400);
    check_beats("parity ok", tf);
    check_errs("parity ok");
    send_frame(8'h07, 1'b0, 1'b1, CPB);
    exp_perr++;
    tick(150);
    check_beats("parity bad", tf);
    check_errs("parity bad");
`endif

    chk("handshake stability", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis_framer.md
Name: uart_rx_axis_framer

Overview:
- UART receive front-end that deserialises the `uart_rx` line into an AXI-Stream master.
- Marks packet boundaries with `tlast`, based on line-idle time after a byte.
- Counterpart of the TX path in the AXIS-UART top: its stream output is the consumer-side `rx_data`/`rx_valid` source for the top-level wrapper.
- Handles receiver buffering and error reporting: framing, overrun and optional parity.

Parameters:
- DATA_BITS, 8, data bits per UART frame and width of `m_axis_tdata`.
- CLKS_PER_BIT, 16, clk cycles per bit period; must be at least 4.
- IDLE_BITS, 4, line-idle bit times after a stop bit that close a packet (`tlast=1`).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- uart_rx  in  1  serial line, idle high, asynchronous to clk
- m_axis_tdata  out  DATA_BITS  received byte
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of a packet
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: completed byte dropped because both buffers are full
- parity_err  out  1  one-cycle pulse; tied 0 when `UART_RX_PARITY_EN` is undefined

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - outputs: `tvalid`, `tlast`, `frame_err`, `overrun`, `parity_err` = 0; `tdata` = 0.
  - internal: FSM = IDLE; synchroniser flops = 1; pending-valid = 0; counters = 0.
  - reset mid-frame discards the partial byte and both buffers.
- Synchroniser: 2-flop on `uart_rx`; the FSM sees only the synchronised value `rxs`.
- FSM states and transitions:
  - IDLE: `rxs==0` -> START, bit counter cleared.
  - START: at cycle CLKS_PER_BIT/2-1, if `rxs==1` (glitch) -> IDLE; else -> DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), LSB first, shifting into the shift register. After DATA_BITS samples -> PARITY if enabled, else STOP.
  - PARITY (feature only): sample one bit -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - `rxs==1`: byte complete -> IDLE.
    - `rxs==0`: `frame_err` pulse, byte discarded -> BREAK.
  - BREAK: wait for `rxs==1` -> IDLE. Prevents a held-low line from re-triggering START.
- Buffering: two stages, pending register (byte plus valid) and output register (`tdata`, `tlast`, `tvalid`).
  - Byte complete, pending empty: byte goes to pending.
  - Byte complete, pending full, output free (or being accepted this cycle): pending moves to output with `tlast=0`; new byte goes to pending.
  - Byte complete, pending full, output occupied and not accepted: `overrun` pulse; new byte dropped; pending unchanged.
- Idle timer:
  - counts while FSM is IDLE and pending is full;
  - cleared on START entry and on each byte complete.
  - At IDLE_BITS*CLKS_PER_BIT: pending moves to output with `tlast=1` once output is free. The timer saturates and the move waits while the output is occupied.
- Handshake:
  - `tvalid`, `tdata`, `tlast` stay stable until `tvalid && tready`.
  - Acceptance and refill in the same cycle are allowed, with no bubble.
- Latency:
  - non-final byte reaches the output the cycle after the next byte's stop sample;
  - final byte reaches the output IDLE_BITS*CLKS_PER_BIT cycles after its stop sample (plus 2 synchroniser cycles from the line).

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - one even-parity bit is sampled after the data bits;
  - a mismatch gives a `parity_err` pulse at the stop sample and the byte is discarded;
  - `frame_err` takes priority when both errors occur; only `frame_err` pulses.
- Undefined: no PARITY state; `parity_err` is constant 0.

Decomposition:
- Shared package `uart_axis_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - bit-counter width function ($clog2 of CLKS_PER_BIT);
  - default constants, shared with the TX side.
- One sub-module `uart_rx_sync`: 2-flop synchroniser with reset value 1.
- Buffering and FSM stay in the top module.

Test Plan:
- All tests use CLKS_PER_BIT=16, IDLE_BITS=4 and `tready=1` unless stated otherwise.
1. Send 0xA5, then idle -> one beat `tdata=0xA5`, `tlast=1`, 64 cycles after the stop sample; no error pulses.
2. Send 0x11, 0x22, 0x33 back-to-back, then idle -> beats 0x11/`tlast=0`, 0x22/`tlast=0`, 0x33/`tlast=1`, in order.
3. Send 0x5A with stop bit 0, line held low 40 cycles then high -> one `frame_err` pulse, no beat, FSM in BREAK until the line is high. A following 0x3C is received correctly.
4. `tready=0`, send 0x01, 0x02, 0x03 back-to-back -> `overrun` pulse at the stop sample of 0x03. After `tready=1`: beats 0x01/`tlast=0`, then 0x02/`tlast=1`.
5. 4-cycle low glitch on an idle line -> no beat and no error pulse. Assert `rst_n` low in the middle of a 0xFF frame -> outputs 0 immediately; no beat after release.
6. `UART_RX_PARITY_EN` defined: send 0x07 with parity bit 1 -> beat 0x07. Send 0x07 with parity bit 0 -> `parity_err` pulse, no beat.
